design88_3_3_top: RTL and testbench
===================================

DESIGN88_3_3_TOP -- requirements
Module: design88_3_3_top

Interface
REQ-001 SHALL have no parameters; all widths are fixed (input 32 bits, output 32 bits).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in  input  32  data word; lower half A = in[15:0], upper half B = in[31:16].
REQ-005 SHALL have port: out  output  32  registered result word, driven directly from stage-2 flops.

Function
REQ-006 SHALL be a two-stage pipeline with no handshake: stage 1 registers in into in_q, and stage 2 registers f(in_q) into out.
REQ-007 SHALL give a new result on out exactly 2 rising edges after in is sampled, and SHALL accept a new word every cycle.
REQ-008 SHALL compute f from A = in_q[15:0] and B = in_q[31:16], both unsigned.
REQ-009 SHALL form SUM[16:0] = A + B as a 17-bit sum with carry kept.
REQ-010 SHALL form ROT[15:0] = B rotated left by 3 (ROT = {B[12:0], B[15:13]}).
REQ-011 SHALL set out[15:0] = SUM[15:0] XOR ROT.
REQ-012 SHALL set out[21:16] = leading-zero count of in_q[31:0]; range 0..32, and an all-zero word gives 32.
REQ-013 SHALL set out[27:22] = population count of in_q[31:0]; range 0..32.
REQ-014 SHALL set out[28] = (A < B), out[29] = (A == B), out[30] = (A > B); exactly one of the three is 1 at any time.
REQ-015 SHALL set out[31] = SUM[16], the carry out of A + B.
REQ-016 SHALL keep all of f combinational between in_q and the out flops; nothing accumulates across cycles.
REQ-017 SHALL pass all 32 bits through the pipeline; none may be truncated.

Reset
REQ-018 SHALL clear in_q and out to 0 immediately on rst assertion, without waiting for a clock edge.
REQ-019 SHALL hold in_q = 0 and out = 0 for as long as rst is high.
REQ-020 SHALL, on the first rising edge after rst deasserts, load out with f(0) = 0x20200000 (eq = 1, leading-zero count = 32).
REQ-021 SHALL, if rst asserts mid-stream, discard all in-flight data; after release, valid results resume 2 edges after the first sampled input.

Verification
REQ-022 Reset, then release with in = 0 -> out = 0x00000000 during reset; 0x20200000 on the first edge after release and on every edge after that.
REQ-023 in = 0x00030005 held for 2 edges -> out = 0x410E0010 (out[15:0] = 0x0010, popcount 4, leading-zero count 14, A > B, no carry).
REQ-024 in = 0xFFFF0001 held for 2 edges -> out = 0x9440FFFF (carry = 1, A < B, popcount 17, leading-zero count 0).
REQ-025 in = 0xFFFFFFFF held for 2 edges -> out = 0xA8000001 (carry = 1, A == B, popcount 32, out[15:0] = 0x0001).
REQ-026 Back-to-back inputs 0x00030005 then 0xFFFFFFFF on consecutive edges -> out shows 0x410E0010, then 0xA8000001 on the next edge.
REQ-027 Assert rst between clock edges while data is in flight -> out goes to 0 at once, with no clock edge needed; normal operation resumes after release per REQ-021.
REQ-028 Random stimulus of 1000 words, each held 2 cycles -> out matches a software model of REQ-008..REQ-015 at every check point.

Source files
------------

// File: rtl/design88_3_3_top.sv
// design88_3_3_top: two-stage pipeline computing a fixed 32-bit word
// transform. Stage 1 captures the input word, stage 2 captures f(in_q).
// f packs: sum/rotate mix, leading-zero count, population count,
// A/B magnitude compare and the A+B carry into one result word.
// There is no handshake: a new word is accepted on every rising edge and
// its result appears on out one edge after it was captured into in_q.
module design88_3_3_top (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in,
    output logic [31:0] out
);

    // Stage-1 register and the two operand halves taken from it.
    logic [31:0] in_q;
    logic [15:0] a;
    logic [15:0] b;

    // Intermediate terms of f.
    logic [16:0] sum;
    logic [15:0] rot;
    logic [15:0] mix;
    logic [5:0]  lzc;
    logic [5:0]  pop;
    logic        a_lt_b;
    logic        a_eq_b;
    logic        a_gt_b;
    logic [31:0] f_word;

    assign a = in_q[15:0];
    assign b = in_q[31:16];

    // Stage 1: capture the raw input word; reset clears it immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q <= 32'd0;
        end else begin
            in_q <= in;
        end
    end

    // 17-bit sum keeps the carry; B rotated left by 3; low half is their XOR.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        rot = {b[12:0], b[15:13]};
        mix = sum[15:0] ^ rot;
    end

    // Leading-zero count: the highest set bit wins because later iterations
    // overwrite earlier ones; an all-zero word keeps the default of 32.
    always_comb begin
        lzc = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (in_q[i]) begin
                lzc = 6'(31 - i);
            end
        end
    end

    // Population count of the whole stage-1 word (0..32 fits in 6 bits).
    always_comb begin
        pop = 6'd0;
        for (int i = 0; i < 32; i++) begin
            pop = pop + {5'd0, in_q[i]};
        end
    end

    // Unsigned magnitude compare; exactly one flag is set at any time.
    always_comb begin
        a_lt_b = 1'b0;
        a_eq_b = 1'b0;
        a_gt_b = 1'b0;
        if (a < b) begin
            a_lt_b = 1'b1;
        end else if (a == b) begin
            a_eq_b = 1'b1;
        end else begin
            a_gt_b = 1'b1;
        end
    end

    // Assemble the result word from the individual fields.
    always_comb begin
        f_word = {sum[16], a_gt_b, a_eq_b, a_lt_b, pop, lzc, mix};
    end

    // Stage 2: register f(in_q) straight onto the output port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= 32'd0;
        end else begin
            out <= f_word;
        end
    end

endmodule

// File: tb/tb_design88_3_3_top.sv
// tb_design88_3_3_top: directed and randomized checks of design88_3_3_top
// against a word-level reference model of the result fields.
module tb_design88_3_3_top;

    logic        clk;
    logic        rst;
    logic [31:0] in_w;
    logic [31:0] out;

    int total;
    int bad;

    // Expected results in output order; the head is the result due next.
    logic [31:0] exp_q[$];

    design88_3_3_top dut (
        .clk (clk),
        .rst (rst),
        .in  (in_w),
        .out (out)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: fields computed arithmetically from the word.
    function automatic logic [31:0] model(input logic [31:0] w);
        int unsigned a;
        int unsigned b;
        int unsigned s;
        int unsigned r;
        int unsigned lz;
        int unsigned pc;
        logic [31:0] res;
        a = w & 32'hFFFF;
        b = w >> 16;
        s = a + b;
        r = ((b << 3) | (b >> 13)) & 32'hFFFF;
        lz = 0;
        while (lz < 32 && w[31 - lz] == 1'b0) lz++;
        pc = $countones(w);
        res = (s & 32'hFFFF) ^ r;
        res = res | (lz << 16) | (pc << 22);
        if (a < b) res = res | (32'd1 << 28);
        else if (a == b) res = res | (32'd1 << 29);
        else res = res | (32'd1 << 30);
        if (s > 32'hFFFF) res = res | (32'd1 << 31);
        return res;
    endfunction

    // Present one word for one edge, then check the result due at that edge.
    task automatic drive(input logic [31:0] w, input string tag);
        in_w = w;
        exp_q.push_back(model(w));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, out, 32'hxxxxxxxx);
        end else begin
            check(tag, out, exp_q.pop_front());
        end
        @(negedge clk);
    endtask

    // Restart the expectation after reset: in_q holds zero, so f(0) is due first.
    task automatic restart_expect();
        exp_q.delete();
        exp_q.push_back(model(32'd0));
    endtask

    initial begin
        logic [31:0] w;
        total = 0;
        bad = 0;
        in_w = 32'd0;
        rst = 1'b1;

        // Reset state: asynchronous clear, held across edges.
        #2;
        check("reset_async", out, 32'h0000_0000);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", out, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        restart_expect();

        // First edges after release with in = 0 give f(0).
        drive(32'd0, "post_reset_0");
        check("f0_const", out, 32'h2020_0000);
        drive(32'd0, "post_reset_1");
        check("f0_const_again", out, 32'h2020_0000);

        // Directed vectors, each held for two edges.
        drive(32'h0003_0005, "a_gt_b_0");
        drive(32'h0003_0005, "a_gt_b_1");
        check("a_gt_b_const", out, 32'h410E_0010);
        drive(32'hFFFF_0001, "a_lt_b_0");
        drive(32'hFFFF_0001, "a_lt_b_1");
        check("a_lt_b_const", out, 32'h9440_FFFF);
        drive(32'hFFFF_FFFF, "a_eq_b_0");
        drive(32'hFFFF_FFFF, "a_eq_b_1");
        check("a_eq_b_const", out, 32'hA800_0001);

        // Back-to-back words on consecutive edges.
        drive(32'h0000_0000, "b2b_flush");
        drive(32'h0003_0005, "b2b_0");
        drive(32'hFFFF_FFFF, "b2b_1");
        check("b2b_first_const", out, 32'h410E_0010);
        drive(32'h8000_0000, "b2b_2");
        check("b2b_second_const", out, 32'hA800_0001);
        drive(32'h0000_0001, "lz_edges_0");
        drive(32'h0000_0001, "lz_edges_1");

        // Reset between edges while data is in flight.
        drive(32'h1234_5678, "inflight_0");
        drive(32'h9ABC_DEF0, "inflight_1");
        #2;
        rst = 1'b1;
        #1;
        check("midreset_async", out, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("midreset_hold", out, 32'h0000_0000);
        @(negedge clk);
        in_w = 32'h5555_AAAA;
        rst = 1'b0;
        restart_expect();
        drive(32'h5555_AAAA, "resume_0");
        check("resume_first_const", out, 32'h2020_0000);
        drive(32'h5555_AAAA, "resume_1");

        // Randomized words, each held for two edges; some forced A == B.
        for (int n = 0; n < 1000; n++) begin
            w = $urandom;
            case ($urandom_range(0, 7))
                0: w[31:16] = w[15:0];
                1: w = w >> $urandom_range(0, 31);
                2: w = 32'd0;
                default: ;
            endcase
            drive(w, "rand_0");
            drive(w, "rand_1");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
